// File: rtl/i2c_slave_axil_bridge.sv
// I2C-slave byte stream to AXI-lite master bridge: address bytes, then write data or read-back bytes.
// Optional AXI response timeout enabled by defining I2C_SLAVE_AXIL_BRIDGE_TIMEOUT_EN.
module i2c_slave_axil_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned AUTO_INC   = 1
`ifdef I2C_SLAVE_AXIL_BRIDGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT  = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_rx_tdata,
  input  logic                  s_axis_rx_tvalid,
  output logic                  s_axis_rx_tready,
  input  logic                  s_axis_rx_tlast,
  output logic [7:0]            m_axis_tx_tdata,
  output logic                  m_axis_tx_tvalid,
  input  logic                  m_axis_tx_tready,
  input  logic                  i2c_start,
  input  logic                  i2c_read,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned ASH_W      = ADDR_BYTES * 8;
  localparam int unsigned ABC_W      = $clog2(ADDR_BYTES + 1);
  localparam int unsigned LANE_W     = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, AXI_AW_W, AXI_B, AXI_AR, AXI_R, TX
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_ptr;
  logic [ASH_W-1:0]       addr_sh;
  logic [ABC_W-1:0]       abyte_cnt;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   last_seen;
  logic                   pend_start;
  logic                   pend_read;

  logic [ADDR_WIDTH-1:0]  addr_inc_c;
  logic [LANE_W-1:0]      lane_c;
  logic [LANE_W-1:0]      lane_inc_c;
  logic                   lane_top_c;
  logic                   rx_hs_c;
  logic                   tx_hs_c;
  logic                   axi_c;
  logic                   tmo_c;
  logic                   resp_done_c;
  logic                   restart_c;
  logic                   start_rd_c;

  function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_WIDTH-1:0] a);
    if (STRB_WIDTH > 1) return a[LANE_W-1:0];
    else return '0;
  endfunction

  assign m_axil_awprot = 3'b010;
  assign m_axil_arprot = 3'b010;

  assign addr_inc_c  = (AUTO_INC != 0) ? addr_ptr + ADDR_WIDTH'(1) : addr_ptr;
  assign lane_c      = lane_of(addr_ptr);
  assign lane_inc_c  = lane_of(addr_inc_c);
  assign lane_top_c  = (lane_c == LANE_W'(STRB_WIDTH - 1));
  assign rx_hs_c     = s_axis_rx_tvalid && s_axis_rx_tready;
  assign tx_hs_c     = m_axis_tx_tvalid && m_axis_tx_tready;
  assign axi_c       = (state == AXI_AW_W) || (state == AXI_B) ||
                       (state == AXI_AR) || (state == AXI_R);
  assign resp_done_c = ((state == AXI_B) && m_axil_bvalid) ||
                       ((state == AXI_R) && m_axil_rvalid) || tmo_c;
  // A START in an AXI state waits until the outstanding response has completed.
  assign restart_c   = (!axi_c && i2c_start) || (resp_done_c && (i2c_start || pend_start));
  assign start_rd_c  = i2c_start ? i2c_read : pend_read;

`ifdef I2C_SLAVE_AXIL_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             progress_c;

  assign progress_c = (m_axil_awvalid && m_axil_awready) || (m_axil_wvalid && m_axil_wready) ||
                      (m_axil_bvalid && m_axil_bready) || (m_axil_arvalid && m_axil_arready) ||
                      (m_axil_rvalid && m_axil_rready);
  assign tmo_c = axi_c && !progress_c && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Cycles spent in an AXI state since the last channel handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tmo_cnt <= '0;
    else if (!axi_c || progress_c) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign tmo_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      addr_ptr         <= '0;
      addr_sh          <= '0;
      abyte_cnt        <= '0;
      rdata_q          <= '0;
      last_seen        <= 1'b0;
      pend_start       <= 1'b0;
      pend_read        <= 1'b0;
      s_axis_rx_tready <= 1'b0;
      m_axis_tx_tdata  <= '0;
      m_axis_tx_tvalid <= 1'b0;
      m_axil_awaddr    <= '0;
      m_axil_awvalid   <= 1'b0;
      m_axil_wdata     <= '0;
      m_axil_wstrb     <= '0;
      m_axil_wvalid    <= 1'b0;
      m_axil_bready    <= 1'b0;
      m_axil_araddr    <= '0;
      m_axil_arvalid   <= 1'b0;
      m_axil_rready    <= 1'b0;
      busy             <= 1'b0;
      error            <= 1'b0;
    end else begin
      if (i2c_start) error <= 1'b0;
      if (axi_c && i2c_start) begin
        pend_start <= 1'b1;
        pend_read  <= i2c_read;
      end

      case (state)
        IDLE: ;

        ADDR: if (rx_hs_c) begin
          addr_sh <= ASH_W'({addr_sh, s_axis_rx_tdata});
          if (abyte_cnt == ABC_W'(ADDR_BYTES - 1)) begin
            addr_ptr <= ADDR_WIDTH'({addr_sh, s_axis_rx_tdata});
            if (s_axis_rx_tlast) begin
              state            <= IDLE;
              s_axis_rx_tready <= 1'b0;
              busy             <= 1'b0;
            end else begin
              state <= WDATA;
            end
          end else if (s_axis_rx_tlast) begin
            state            <= IDLE;
            s_axis_rx_tready <= 1'b0;
            busy             <= 1'b0;
          end else begin
            abyte_cnt <= abyte_cnt + ABC_W'(1);
          end
        end

        WDATA: if (rx_hs_c) begin
          m_axil_wdata[int'(lane_c)*8 +: 8] <= s_axis_rx_tdata;
          m_axil_wstrb[lane_c]              <= 1'b1;
          addr_ptr                          <= addr_inc_c;
          last_seen                         <= s_axis_rx_tlast;
          if (lane_top_c || s_axis_rx_tlast || (AUTO_INC == 0)) begin
            state            <= AXI_AW_W;
            s_axis_rx_tready <= 1'b0;
            m_axil_awaddr    <= addr_ptr & ALIGN_MASK;
            m_axil_awvalid   <= 1'b1;
            m_axil_wvalid    <= 1'b1;
          end
        end

        AXI_AW_W: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          if (tmo_c) begin
            m_axil_awvalid   <= 1'b0;
            m_axil_wvalid    <= 1'b0;
            m_axil_wstrb     <= '0;
            error            <= 1'b1;
            last_seen        <= 1'b0;
            state            <= last_seen ? IDLE : WDATA;
            s_axis_rx_tready <= !last_seen;
            busy             <= !last_seen;
          end else if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
            state         <= AXI_B;
            m_axil_bready <= 1'b1;
          end
        end

        AXI_B: if (m_axil_bvalid || tmo_c) begin
          m_axil_bready    <= 1'b0;
          m_axil_wstrb     <= '0;
          if (tmo_c || (m_axil_bresp != 2'b00)) error <= 1'b1;
          last_seen        <= 1'b0;
          state            <= last_seen ? IDLE : WDATA;
          s_axis_rx_tready <= !last_seen;
          busy             <= !last_seen;
        end

        AXI_AR: begin
          if (tmo_c) begin
            m_axil_arvalid   <= 1'b0;
            error            <= 1'b1;
            rdata_q          <= '1;
            state            <= TX;
            m_axis_tx_tvalid <= 1'b1;
            m_axis_tx_tdata  <= 8'hFF;
          end else if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= AXI_R;
          end
        end

        AXI_R: begin
          if (tmo_c) begin
            m_axil_rready    <= 1'b0;
            error            <= 1'b1;
            rdata_q          <= '1;
            state            <= TX;
            m_axis_tx_tvalid <= 1'b1;
            m_axis_tx_tdata  <= 8'hFF;
          end else if (m_axil_rvalid) begin
            m_axil_rready    <= 1'b0;
            rdata_q          <= m_axil_rdata;
            if (m_axil_rresp != 2'b00) error <= 1'b1;
            state            <= TX;
            m_axis_tx_tvalid <= 1'b1;
            m_axis_tx_tdata  <= m_axil_rdata[int'(lane_c)*8 +: 8];
          end
        end

        TX: if (tx_hs_c) begin
          addr_ptr <= addr_inc_c;
          if (lane_top_c || (AUTO_INC == 0)) begin
            m_axis_tx_tvalid <= 1'b0;
            state            <= AXI_AR;
            m_axil_arvalid   <= 1'b1;
            m_axil_araddr    <= addr_inc_c & ALIGN_MASK;
          end else begin
            m_axis_tx_tdata <= rdata_q[int'(lane_inc_c)*8 +: 8];
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // New addressed START: drop any partial transfer and re-enter by direction.
      if (restart_c) begin
        pend_start       <= 1'b0;
        last_seen        <= 1'b0;
        abyte_cnt        <= '0;
        m_axil_wstrb     <= '0;
        m_axil_awvalid   <= 1'b0;
        m_axil_wvalid    <= 1'b0;
        m_axis_tx_tvalid <= 1'b0;
        busy             <= 1'b1;
        m_axil_arvalid   <= start_rd_c;
        if (start_rd_c) begin
          state            <= AXI_AR;
          m_axil_araddr    <= addr_ptr & ALIGN_MASK;
          s_axis_rx_tready <= 1'b0;
        end else begin
          state            <= ADDR;
          s_axis_rx_tready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/i2c_slave_axil_bridge.md
I2C_SLAVE_AXIL_BRIDGE -- requirements
Module: i2c_slave_axil_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-lite data width (8, 16, 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI-lite byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have parameter AUTO_INC, default 1, 1 = byte address increments per data byte, 0 = address fixed.
REQ-005 SHALL have clk  in  1  sole clock; rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have s_axis_rx_tdata/tvalid/tready/tlast  in/in/out/in  8/1/1/1  bytes written by the I2C master; tlast marks the byte before STOP or repeated START.
REQ-007 SHALL have m_axis_tx_tdata/tvalid/tready  out/out/in  8/1/1  bytes returned to the I2C master.
REQ-008 SHALL have i2c_start  in  1  one-cycle pulse on each addressed START/repeated START; i2c_read  in  1  R/W bit, valid with i2c_start.
REQ-009 SHALL have m_axil_aw*/w*/b*/ar*/r*  AXI-lite master channels, ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH wide, awprot/arprot  out  3  fixed 3'b010.
REQ-010 SHALL have busy  out  1  state not IDLE; error  out  1  sticky error, cleared on i2c_start.

Function
REQ-011 SHALL use ADDR_BYTES = ceil(ADDR_WIDTH/8); the first ADDR_BYTES bytes of a write transfer form the byte address, MSB first.
REQ-012 SHALL implement states IDLE, ADDR, WDATA, AXI_AW_W, AXI_B, AXI_AR, AXI_R, TX.
REQ-013 SHALL go IDLE->ADDR on i2c_start with i2c_read=0, IDLE->AXI_AR on i2c_start with i2c_read=1.
REQ-014 SHALL commit the address pointer only after all ADDR_BYTES arrive; tlast before that discards the partial address and returns to IDLE.
REQ-015 SHALL place each data byte in lane addr[log2(STRB_WIDTH)-1:0], set that strobe bit, then advance address per AUTO_INC (wraps modulo 2^ADDR_WIDTH).
REQ-016 SHALL go WDATA->AXI_AW_W when the top lane is filled, on tlast with any strobe set, or when AUTO_INC=0 after every byte.
REQ-017 SHALL assert awvalid and wvalid together, drop each independently on its ready, awaddr word-aligned, then enter AXI_B with bready=1.
REQ-018 SHALL clear strobes on bvalid, set error if bresp!=0, return to WDATA (IDLE if tlast consumed).
REQ-019 SHALL hold s_axis_rx_tready low in AXI_AW_W and AXI_B; high in ADDR and WDATA.
REQ-020 SHALL fetch the aligned word in AXI_AR/AXI_R (rready=1), set error if rresp!=0, then present the current-lane byte in TX.
REQ-021 SHALL advance lane on each tx handshake; after top lane (or every byte when AUTO_INC=0) fetch the next word via AXI_AR.
REQ-022 SHALL, on i2c_start in any non-AXI state, abandon the current transfer and re-enter per REQ-013; in AXI states defer it until the response completes.
REQ-023 SHALL accept tlast with zero data bytes as address-set only (no AXI write).

Reset
REQ-024 SHALL on rst force IDLE, address 0, strobes 0, all valid outputs 0, all ready outputs 0, busy 0, error 0, regardless of clk, including mid-AXI transfer.

Configuration
REQ-025 SHALL, with I2C_SLAVE_AXIL_BRIDGE_TIMEOUT_EN defined, add parameter TIMEOUT (default 1024) and abort any AXI state after TIMEOUT cycles without response: drop valids, set error, read byte returned 8'hFF.
REQ-026 SHALL, without I2C_SLAVE_AXIL_BRIDGE_TIMEOUT_EN, wait indefinitely for AXI responses and contain no timeout counter.

Verification
REQ-027 SHALL cover write: start rd=0, bytes 00 10 11 22 33 44 tlast -> one AXI write awaddr 0x0010, wdata 0x44332211, wstrb 4'hF.
REQ-028 SHALL cover partial write: bytes 00 11 AA BB tlast -> awaddr 0x0010, wdata[23:8]=0xBBAA, wstrb 4'h6.
REQ-029 SHALL cover read: set address 0x0012, repeated start rd=1, rdata 0xDDCCBBAA, read 4 bytes -> tx CC DD then second AR at 0x0014.
REQ-030 SHALL cover errors: bresp=2'b10 -> error=1 until next i2c_start; rresp=2'b11 likewise.
REQ-031 SHALL cover timeout (macro defined, TIMEOUT=16): arready held 0 -> arvalid drops after 16 cycles, error=1, tx byte 0xFF.
REQ-032 SHALL cover rst asserted during AXI_AW_W -> awvalid, wvalid, busy low immediately, next transfer completes correctly.
